// File: rtl/db_write_ctrl.sv
// Write-side controller of the USB endpoint data buffer: arbitrates TX/RX store
// requests, drives the buffer RAM write port and owns the occupancy count.
module db_write_ctrl #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int PTR_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_packet_data,
    input  logic              store_rx_packet_data,
    input  logic [DATA_W-1:0] rx_packet_data,
    input  logic              read_en,
    input  logic              clear,
    input  logic              flush,
    output logic              write_en,
    output logic [PTR_W-1:0]  write_ptr,
    output logic [DATA_W-1:0] write_data,
    output logic [PTR_W-1:0]  buff_occ,
    output logic              buff_full,
    output logic              overflow
);

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    logic [PTR_W-1:0]  next_slot;
    logic              req;
    logic              accept;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] sel_data;
    logic [PTR_W-1:0]  occ_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req      = store_tx_data | store_rx_packet_data;
        accept   = req && (buff_occ < DEPTH_P);
        pop      = read_en && (buff_occ != '0);
        // TX wins a simultaneous request; the RX byte is lost and flagged.
        drop     = (store_tx_data && store_rx_packet_data) || (req && !accept);
        sel_data = store_tx_data ? tx_packet_data : rx_packet_data;
        occ_next = buff_occ;
        if (accept && !pop) begin
            occ_next = buff_occ + ONE_P;
        end else if (!accept && pop) begin
            occ_next = buff_occ - ONE_P;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_en   <= 1'b0;
            write_ptr  <= '0;
            write_data <= '0;
            buff_occ   <= '0;
            buff_full  <= 1'b0;
            overflow   <= 1'b0;
            next_slot  <= '0;
        end else if (clear || flush) begin
            // Any byte still in flight is discarded along with the contents.
            write_en  <= 1'b0;
            write_ptr <= '0;
            buff_occ  <= '0;
            buff_full <= 1'b0;
            overflow  <= 1'b0;
            next_slot <= '0;
        end else begin
            write_en  <= accept;
            buff_occ  <= occ_next;
            buff_full <= (occ_next == DEPTH_P);
            if (drop) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                write_data <= sel_data;
                write_ptr  <= next_slot;
                next_slot  <= (next_slot == LAST_P) ? '0 : next_slot + ONE_P;
            end
        end
    end

endmodule
